// File: rtl/read_ctrl_pkg.sv
// Shared types and constants for the event-buffer read controller.
// Header length field location and the default payload limit live here.
package read_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SUBMIT = 3'd1,
        HDR    = 3'd2,
        FETCH  = 3'd3,
        DATA   = 3'd4
    } state_t;

    localparam int LEN_LSB         = 0;
    localparam int LEN_W           = 10;
    localparam int MAX_LEN_DEFAULT = 64;

endpackage

// File: rtl/read_control_if.sv
// Output word stream of the read controller.
// Handshake: a word moves on a rising clk edge where out_valid && out_ready; while
// out_valid is high and out_ready low, out_data and out_last are held unchanged;
// out_last is meaningful only together with out_valid.
interface read_control_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;

    modport master (
        output out_data,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/read_control.sv
// Claims queued events from the event buffer and streams header plus payload words.
// The read address runs one word ahead so each word costs one FETCH bubble only.
module read_control
    import read_ctrl_pkg::*;
#(
    parameter int ADDR_W  = 11,
    parameter int DATA_W  = 16,
    parameter int MAX_LEN = MAX_LEN_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                live_rising,
    input  logic                r_request,
    output logic                r_submit,
    output logic [ADDR_W-1:0]   rd_addr,
    input  logic [DATA_W-1:0]   rd_data,
    read_control_if.master      out_if,
    output logic                busy,
    output logic                err_len,
    output state_t              fsm_state
);

    localparam logic [LEN_W-1:0] MAX_LEN_V = LEN_W'(MAX_LEN);

    state_t             state;
    logic [ADDR_W-1:0]  rd_ptr;
    logic [LEN_W-1:0]   remaining;
    logic [DATA_W-1:0]  data_q;
    logic               valid_q;
    logic               last_q;
    logic [LEN_W-1:0]   hdr_n;
    logic [LEN_W-1:0]   hdr_clamped;

    assign hdr_n       = rd_data[LEN_LSB +: LEN_W];
    assign hdr_clamped = (hdr_n > MAX_LEN_V) ? MAX_LEN_V : hdr_n;

    assign out_if.out_data  = data_q;
    assign out_if.out_valid = valid_q;
    assign out_if.out_last  = last_q;
    assign busy             = (state != IDLE);
    assign fsm_state        = state;

    always_ff @(posedge clk) begin
        if (!rst_n || live_rising) begin
            state     <= IDLE;
            rd_ptr    <= '0;
            remaining <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            r_submit  <= 1'b0;
            rd_addr   <= '0;
            err_len   <= 1'b0;
        end else begin
            r_submit <= 1'b0;
            case (state)
                IDLE: begin
                    if (r_request) begin
                        state    <= SUBMIT;
                        r_submit <= 1'b1;
                        rd_addr  <= rd_ptr;
                    end
                end
                SUBMIT: begin
                    state <= HDR;
                end
                HDR: begin
                    // First HDR cycle captures the header; later cycles wait for the transfer.
                    if (!valid_q) begin
                        data_q    <= rd_data;
                        valid_q   <= 1'b1;
                        last_q    <= (hdr_clamped == '0);
                        remaining <= hdr_clamped;
                        rd_addr   <= rd_addr + 1'b1;
                        if (hdr_n > MAX_LEN_V) begin
                            err_len <= 1'b1;
                        end
                    end else if (out_if.out_ready) begin
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                        if (remaining == '0) begin
                            state  <= IDLE;
                            rd_ptr <= rd_addr;
                        end else begin
                            state <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    data_q  <= rd_data;
                    valid_q <= 1'b1;
                    last_q  <= (remaining == LEN_W'(1));
                    rd_addr <= rd_addr + 1'b1;
                    state   <= DATA;
                end
                DATA: begin
                    if (out_if.out_ready) begin
                        valid_q   <= 1'b0;
                        last_q    <= 1'b0;
                        remaining <= remaining - 1'b1;
                        // rd_addr already points one past the final word read.
                        if (remaining == LEN_W'(1)) begin
                            state  <= IDLE;
                            rd_ptr <= rd_addr;
                        end else begin
                            state <= FETCH;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_read_control.sv
// Directed bench for read_control: event table plus restart/reset sequences,
// with a behavioural synchronous RAM standing in for the event buffer.
module tb_read_control;
    import read_ctrl_pkg::*;

    localparam int ADDR_W  = 11;
    localparam int DATA_W  = 16;
    localparam int MAX_LEN = 64;
    localparam int DEPTH   = 2048;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               live_rising = 1'b0;
    logic               r_request = 1'b0;
    logic               r_submit;
    logic [ADDR_W-1:0]  rd_addr;
    logic [DATA_W-1:0]  rd_data;
    logic               busy;
    logic               err_len;
    state_t             fsm_state;

    read_control_if #(.DATA_W(DATA_W)) out_if ();

    read_control #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .MAX_LEN (MAX_LEN)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .live_rising (live_rising),
        .r_request   (r_request),
        .r_submit    (r_submit),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .out_if      (out_if),
        .busy        (busy),
        .err_len     (err_len),
        .fsm_state   (fsm_state)
    );

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] exp_q [$];
    int checks = 0;
    int errors = 0;

    typedef struct {
        int n;
        int stall_at;
        int stall_len;
        int exp_start;
        bit exp_err;
    } vec_t;
    vec_t vecs [$];

    always #5 clk = ~clk;

    always @(posedge clk) rd_data <= mem[rd_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic check_idle(input string tag, input int exp_addr);
        check({tag, "_r_submit"}, r_submit, 0);
        check({tag, "_out_valid"}, out_if.out_valid, 0);
        check({tag, "_out_last"}, out_if.out_last, 0);
        check({tag, "_out_data"}, out_if.out_data, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_err_len"}, err_len, 0);
        check({tag, "_rd_addr"}, rd_addr, exp_addr);
        check({tag, "_state"}, 32'(fsm_state), 32'(IDLE));
    endtask

    task automatic load_event(input int n, input int start);
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] w;
        int clamp;
        clamp = (n > MAX_LEN) ? MAX_LEN : n;
        exp_q.delete();
        a = ADDR_W'(start);
        w = {6'(n % 63 + 1), 10'(n)};
        mem[a] = w;
        exp_q.push_back(w);
        for (int k = 1; k <= clamp; k++) begin
            a = a + 1'b1;
            w = {5'(k), a};
            mem[a] = w;
            exp_q.push_back(w);
        end
    endtask

    task automatic wait_submit(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 8 && !ok; i++) begin
            @(negedge clk);
            if (r_submit) ok = 1'b1;
        end
        check("submit_seen", ok, 1);
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge clk);
            if (out_if.out_valid) ok = 1'b1;
        end
        check("valid_seen", ok, 1);
    endtask

    task automatic run_event(input int n, input int stall_at, input int stall_len,
                             input int start, input bit exp_err, input bit with_live);
        int words;
        int subs;
        int got;
        int last_t;
        int stall_left;
        bit ok;
        logic [DATA_W-1:0] held_d;
        logic [DATA_W-1:0] w;
        logic held_l;
        words = ((n > MAX_LEN) ? MAX_LEN : n) + 1;
        held_d = '0;
        held_l = 1'b0;
        if (with_live) begin
            r_request   = 1'b1;
            live_rising = 1'b1;
            @(negedge clk);
            check("live_vs_request_submit", r_submit, 0);
            check("live_vs_request_state", 32'(fsm_state), 32'(IDLE));
            live_rising = 1'b0;
        end
        load_event(n, start);
        r_request = 1'b1;
        wait_submit(ok);
        if (ok) begin
            check("submit_addr", rd_addr, start);
            check("submit_busy", busy, 1);
            subs = 1;
            got = 0;
            last_t = 0;
            stall_left = stall_len;
            for (int cyc = 1; cyc <= 4 * words + 20 && got < words; cyc++) begin
                @(negedge clk);
                r_request = 1'b0;
                if (r_submit) subs++;
                if (out_if.out_valid) begin
                    if (got == stall_at && stall_left > 0) begin
                        if (stall_left == stall_len) begin
                            held_d = out_if.out_data;
                            held_l = out_if.out_last;
                            out_if.out_ready = 1'b0;
                        end else begin
                            check("stall_data_stable", out_if.out_data, held_d);
                            check("stall_last_stable", out_if.out_last, held_l);
                        end
                        stall_left--;
                    end else begin
                        out_if.out_ready = 1'b1;
                        if (stall_len == 0) check("word_spacing", cyc - last_t, 2);
                        last_t = cyc;
                        w = exp_q.pop_front();
                        check("word_data", out_if.out_data, w);
                        check("word_last", out_if.out_last, (exp_q.size() == 0));
                        check("err_len", err_len, exp_err);
                        got++;
                    end
                end
            end
            check("words_emitted", got, words);
            @(negedge clk);
            if (r_submit) subs++;
            check("end_state", 32'(fsm_state), 32'(IDLE));
            check("end_busy", busy, 0);
            check("end_valid", out_if.out_valid, 0);
            check("submit_once", subs, 1);
        end
        r_request = 1'b0;
        out_if.out_ready = 1'b1;
    endtask

    initial begin
        bit ok;
        int subs;
        logic [DATA_W-1:0] w;

        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        out_if.out_ready = 1'b1;

        // Clock/reset
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_idle("reset", 0);
        rst_n = 1'b1;

        // Event table: pointer walks 0,4,5,11, then fillers up to 2046 and across the wrap.
        vecs.push_back('{3, 0, 0, 0, 1'b0});
        vecs.push_back('{0, 0, 0, 4, 1'b0});
        vecs.push_back('{5, 2, 5, 5, 1'b0});
        for (int i = 0; i < 31; i++) vecs.push_back('{64, 0, 0, 11 + 65 * i, 1'b0});
        vecs.push_back('{19, 0, 0, 2026, 1'b0});
        vecs.push_back('{3, 0, 0, 2046, 1'b0});
        vecs.push_back('{100, 0, 0, 2, 1'b1});
        vecs.push_back('{2, 0, 0, 67, 1'b1});
        vecs.push_back('{1, 0, 0, 70, 1'b1});

        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            run_event(vecs[i].n, vecs[i].stall_at, vecs[i].stall_len,
                      vecs[i].exp_start, vecs[i].exp_err, 1'b0);
        end

        // Restart in the middle of an N=10 event at word index 2.
        load_event(10, 72);
        r_request = 1'b1;
        wait_submit(ok);
        @(negedge clk);
        r_request = 1'b0;
        for (int k = 0; k < 3; k++) begin
            wait_valid(ok);
            w = exp_q.pop_front();
            check("live_pre_word", out_if.out_data, w);
        end
        check("live_in_data", 32'(fsm_state), 32'(DATA));
        live_rising = 1'b1;
        @(negedge clk);
        live_rising = 1'b0;
        check_idle("live", 0);
        subs = 0;
        repeat (4) begin
            @(negedge clk);
            if (r_submit) subs++;
        end
        check("live_no_submit", subs, 0);
        run_event(2, 0, 0, 0, 1'b0, 1'b1);
        run_event(1, 0, 0, 3, 1'b0, 1'b0);

        // Reset during an event: abandoned, not replayed.
        load_event(5, 5);
        r_request = 1'b1;
        wait_submit(ok);
        @(negedge clk);
        r_request = 1'b0;
        wait_valid(ok);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_idle("mid_reset", 0);
        subs = 0;
        repeat (5) begin
            @(negedge clk);
            if (r_submit) subs++;
        end
        check("mid_reset_no_submit", subs, 0);
        check("mid_reset_idle", 32'(fsm_state), 32'(IDLE));
        run_event(0, 0, 0, 0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/read_control.md
READ_CONTROL -- requirements
Module: read_control

Interface
REQ-001 SHALL have parameter ADDR_W, default 11: event buffer address width (2048 words).
REQ-002 SHALL have parameter DATA_W, default 16: event buffer and output word width.
REQ-003 SHALL have parameter MAX_LEN, default 64: maximum payload words per event.
REQ-004 clk  in  1  system clock; all logic on posedge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 live_rising  in  1  run-start pulse; synchronous restart of the block.
REQ-007 r_request  in  1  high while at least one complete event is queued, from queue_control.
REQ-008 r_submit  out  1  one-cycle pulse, event claimed; decrements queue_control count.
REQ-009 rd_addr  out  ADDR_W  event buffer read address; synchronous RAM, data valid 1 cycle later.
REQ-010 rd_data  in  DATA_W  event buffer read data.
REQ-011 out_data  out  DATA_W  output word.
REQ-012 out_valid  out  1  out_data valid.
REQ-013 out_ready  in  1  downstream accepts; transfer when out_valid && out_ready.
REQ-014 out_last  out  1  marks final word of the event; qualified by out_valid.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 err_len  out  1  sticky: header length exceeded MAX_LEN.

Function
REQ-017 Event format: word at rd_ptr is the header; header[9:0] = N payload words following; emitted words = N+1, header first.
REQ-018 FSM states: IDLE, SUBMIT, HDR, FETCH, DATA.
REQ-019 IDLE: if r_request=1, go to SUBMIT next cycle; otherwise hold.
REQ-020 SUBMIT, exactly one cycle: r_submit=1, rd_addr=rd_ptr; go to HDR.
REQ-021 HDR: latch rd_data as header; present it with out_valid=1; load remaining count with N.
REQ-022 If N=0, the header carries out_last=1.
REQ-023 If N>MAX_LEN: clamp remaining count to MAX_LEN; set err_len at the HDR cycle.
REQ-024 On a transfer in HDR or DATA: if remaining=0, go to IDLE and advance rd_ptr by emitted words mod 2^ADDR_W; else go to FETCH.
REQ-025 FETCH, one cycle: out_valid=0, rd_addr=next address; go to DATA.
REQ-026 DATA: present rd_data (captured) with out_valid=1; decrement remaining on transfer; out_last=1 when remaining=1.
REQ-027 While out_valid=1 and out_ready=0, out_data, out_last and state hold stable.
REQ-028 Throughput: one word per 2 cycles at out_ready=1; header out 2 cycles after r_submit.
REQ-029 Addresses wrap modulo 2^ADDR_W with no gap; an event may straddle the wrap.
REQ-030 r_submit fires exactly once per event; IDLE is re-entered before the next r_request is sampled, so the one-cycle lag in r_request falling causes no double claim.
REQ-031 live_rising=1 in any state: next cycle IDLE, rd_ptr=0, err_len=0, outputs at reset values, event in progress discarded.
REQ-032 live_rising=1 together with r_request=1: the restart wins; r_request is re-sampled next cycle.

Reset
REQ-033 rst_n=0 at a clock edge: state=IDLE, rd_ptr=0, remaining=0, r_submit=0, out_valid=0, out_last=0, out_data=0, rd_addr=0, busy=0, err_len=0.
REQ-034 Reset mid-event abandons the event with no further r_submit; the aborted event is not replayed.

Structure
REQ-035 Shared package read_ctrl_pkg SHALL hold the FSM state type, header length field position/width (bits 9:0), and MAX_LEN default.
REQ-036 Single flat module; no sub-module.

Verification
REQ-037 Header N=3 at addr 0, out_ready=1, r_request pulse -> r_submit one cycle; 4 words at 2-cycle spacing; out_last on 4th word; rd_ptr=4.
REQ-038 N=0 event -> single header word with out_last=1; rd_ptr advances by 1; back to IDLE.
REQ-039 rd_ptr=2046, N=3 -> reads addresses 2046, 2047, 0, 1; final rd_ptr=2.
REQ-040 N=100, MAX_LEN=64 -> err_len=1 at HDR; 65 words emitted; rd_ptr advances 65; err_len stays 1 until reset or live_rising.
REQ-041 out_ready held 0 for 5 cycles during DATA -> out_data/out_last stable; no word lost or duplicated.
REQ-042 live_rising during DATA of an N=10 event -> out_valid=0 next cycle; rd_ptr=0; next r_request gives a fresh r_submit.
